// File: rtl/pe_matrix_pkg.sv
// Shared types and indexing helper for the parametrised PE matrix.
package pe_matrix_pkg;

  typedef enum logic [1:0] {
    SRC_BUS     = 2'd0,
    SRC_DIAG_UP = 2'd1,
    SRC_DIAG_DN = 2'd2,
    SRC_HORZ    = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_FULL = 2'd2
  } wl_state_e;

  // Column-major flat index, shared by the feature bus, product bus and loader.
  function automatic int unsigned flat_idx(input int unsigned c, input int unsigned r,
                                           input int unsigned rows);
    return c * rows + r;
  endfunction

endpackage

// File: rtl/pe_cell.sv
// One multiply PE: source-muxed feature register, shadow/active weights
// and a registered full-width signed product.
module pe_cell
  import pe_matrix_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [1:0]            sel,
  input  logic [DATA_W-1:0]     src_bus,
  input  logic [DATA_W-1:0]     src_up,
  input  logic [DATA_W-1:0]     src_dn,
  input  logic [DATA_W-1:0]     src_horz,
  input  logic                  prod_en,
  input  logic                  w_wr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic                  w_swap,
  output logic [DATA_W-1:0]     q,
  output logic [2*DATA_W-1:0]   p
);
  logic [DATA_W-1:0]   q_q, q_d;
  logic [DATA_W-1:0]   w_act_q, w_act_d;
  logic [DATA_W-1:0]   w_shd_q, w_shd_d;
  logic [2*DATA_W-1:0] p_q, p_d;
  logic [2*DATA_W-1:0] q_ext, w_ext;

  // Sign-extend both operands so the low 2*DATA_W bits of the product are the signed result.
  assign q_ext = {{DATA_W{q_q[DATA_W-1]}}, q_q};
  assign w_ext = {{DATA_W{w_act_q[DATA_W-1]}}, w_act_q};

  // Next-state selection for feature, weights and product.
  always_comb begin
    q_d     = q_q;
    w_act_d = w_act_q;
    w_shd_d = w_shd_q;
    p_d     = p_q;
    if (in_valid) begin
      case (src_sel_e'(sel))
        SRC_BUS:     q_d = src_bus;
        SRC_DIAG_UP: q_d = src_up;
        SRC_DIAG_DN: q_d = src_dn;
        SRC_HORZ:    q_d = src_horz;
        default:     q_d = src_bus;
      endcase
    end else begin
      q_d = q_q;
    end
    if (prod_en) begin
      p_d = q_ext * w_ext;
    end else begin
      p_d = p_q;
    end
    if (w_wr) begin
      w_shd_d = w_data;
    end else begin
      w_shd_d = w_shd_q;
    end
    if (w_swap) begin
      w_act_d = w_shd_q;
    end else begin
      w_act_d = w_act_q;
    end
  end

  // Cell state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q     <= '0;
      w_act_q <= '0;
      w_shd_q <= '0;
      p_q     <= '0;
    end else begin
      q_q     <= q_d;
      w_act_q <= w_act_d;
      w_shd_q <= w_shd_d;
      p_q     <= p_d;
    end
  end

  assign q = q_q;
  assign p = p_q;

endmodule

// File: rtl/pe_matrix_param.sv
// ROWS x COLS multiply-PE grid with edge zero-fill, valid pipeline and a
// handshake-driven double-buffered weight loader.
module pe_matrix_param
  import pe_matrix_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROWS   = 11,
  parameter int COLS   = 11
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [2*COLS-1:0]               sel,
  input  logic                            in_valid,
  input  logic [COLS*ROWS*DATA_W-1:0]     bus_if,
  input  logic                            w_load_start,
  input  logic                            w_valid,
  input  logic [DATA_W-1:0]               w_data,
  output logic                            w_ready,
  output logic                            w_full,
  input  logic                            w_swap,
  output logic                            out_valid,
  output logic [COLS*ROWS*2*DATA_W-1:0]   bus_p,
  output logic [COLS*ROWS*DATA_W-1:0]     bus_q
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  wl_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             w_ready_q, w_ready_d;
  logic             w_full_q, w_full_d;
  logic             q_v_q, q_v_d;
  logic             out_valid_q, out_valid_d;
  logic             load_we, swap_en;

  // Loader next state; a restart in LOAD takes priority over a same-cycle word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      W_IDLE: begin
        if (w_load_start) begin
          state_d = W_LOAD;
          idx_d   = '0;
        end else begin
          state_d = W_IDLE;
        end
      end
      W_LOAD: begin
        if (w_load_start) begin
          idx_d = '0;
        end else if (w_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d = W_FULL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      W_FULL: begin
        if (w_swap) begin
          state_d = w_load_start ? W_LOAD : W_IDLE;
          idx_d   = '0;
        end else if (w_load_start) begin
          state_d = W_LOAD;
          idx_d   = '0;
        end else begin
          state_d = W_FULL;
        end
      end
      default: begin
        state_d = W_IDLE;
        idx_d   = '0;
      end
    endcase
    w_ready_d   = (state_d == W_LOAD);
    w_full_d    = (state_d == W_FULL);
    q_v_d       = in_valid;
    out_valid_d = q_v_q;
  end

  assign load_we = (state_q == W_LOAD) && w_valid && !w_load_start;
  assign swap_en = (state_q == W_FULL) && w_swap;

  // Loader FSM, its registered flags and the valid pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= W_IDLE;
      idx_q       <= '0;
      w_ready_q   <= 1'b0;
      w_full_q    <= 1'b0;
      q_v_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      w_ready_q   <= w_ready_d;
      w_full_q    <= w_full_d;
      q_v_q       <= q_v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign w_ready   = w_ready_q;
  assign w_full    = w_full_q;
  assign out_valid = out_valid_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int unsigned IDX = flat_idx(c, r, ROWS);
      logic [DATA_W-1:0] up_s, dn_s, horz_s;

      // Neighbours outside the grid read as zero.
      if (c > 0 && r < ROWS - 1) begin : g_up
        assign up_s = bus_q[flat_idx(c - 1, r + 1, ROWS)*DATA_W +: DATA_W];
      end else begin : g_up_zero
        assign up_s = '0;
      end
      if (c < COLS - 1 && r > 0) begin : g_dn
        assign dn_s = bus_q[flat_idx(c + 1, r - 1, ROWS)*DATA_W +: DATA_W];
      end else begin : g_dn_zero
        assign dn_s = '0;
      end
      if (c > 0) begin : g_horz
        assign horz_s = bus_q[flat_idx(c - 1, r, ROWS)*DATA_W +: DATA_W];
      end else begin : g_horz_zero
        assign horz_s = '0;
      end

      pe_cell #(.DATA_W(DATA_W)) u_cell (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .sel      (sel[2*c +: 2]),
        .src_bus  (bus_if[IDX*DATA_W +: DATA_W]),
        .src_up   (up_s),
        .src_dn   (dn_s),
        .src_horz (horz_s),
        .prod_en  (q_v_q),
        .w_wr     (load_we && (idx_q == IDX_W'(IDX))),
        .w_data   (w_data),
        .w_swap   (swap_en),
        .q        (bus_q[IDX*DATA_W +: DATA_W]),
        .p        (bus_p[IDX*2*DATA_W +: 2*DATA_W])
      );
    end
  end

endmodule

// File: doc/pe_matrix_param.md
Name: pe_matrix_param

Overview:
- Parametrised successor to the fixed 11x11 PE matrix.
- Implements a ROWS x COLS grid of multiply PEs. Each PE has:
  - a registered input-feature stage Q;
  - a per-column 4-way streaming source select (bus, anti-diagonal up, anti-diagonal down, horizontal);
  - a registered signed product.
- Adds three things the old matrix lacks: a handshake-driven, double-buffered weight loader; valid/stall pipelining; and zero-fill at grid edges.
- Sits between the feature buffer / weight SRAM and the accumulator tree of the CNN engine.

Parameters:
- DATA_W, 16, signed feature/weight width
- ROWS, 11, PEs per column (>=1)
- COLS, 11, number of columns (>=1)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- sel  in  2*COLS  per-column source select; column c uses sel[2c+1:2c]
- in_valid  in  1  advance the feature stage this cycle
- bus_if  in  COLS*ROWS*DATA_W  feature bus; PE(c,r) at bits [(c*ROWS+r)*DATA_W +: DATA_W]
- w_load_start  in  1  begin filling the shadow weight bank
- w_valid  in  1  weight word present
- w_data  in  DATA_W  weight word
- w_ready  out  1  loader accepts w_data
- w_full  out  1  shadow bank complete, awaiting swap
- w_swap  in  1  commit shadow bank to active bank
- out_valid  out  1  bus_p holds a new product set
- bus_p  out  COLS*ROWS*2*DATA_W  products; PE(c,r) at [(c*ROWS+r)*2*DATA_W +: 2*DATA_W]
- bus_q  out  COLS*ROWS*DATA_W  current Q of every PE (cascade/debug)

Behaviour:
- Reset: every Q, P, active weight and shadow weight = 0; out_valid=0; loader state = IDLE; w_ready=0; w_full=0. RST mid-load discards the partial shadow contents and returns to IDLE.
- Source select for PE(c,r), evaluated when in_valid=1; Q <= chosen source:
  - sel=0: bus_if(c,r)
  - sel=1: Q(c-1,r+1), anti-diagonal from the upper right
  - sel=2: Q(c+1,r-1), anti-diagonal from the lower left
  - sel=3: Q(c-1,r), horizontal shift
  - a non-existent neighbour (outside the grid) reads 0
  - all sources are the pre-edge Q values, so the whole grid shifts simultaneously (no ripple).
- Stall: in_valid=0 holds every Q.
- Product stage:
  - q_v <= in_valid
  - when q_v=1: P(c,r) <= signed(Q(c,r)) * signed(W_active(c,r)), full 2*DATA_W width, no saturation or rounding
  - out_valid <= q_v
  - latency: in_valid at edge t -> bus_p/out_valid valid after edge t+2
  - P holds when q_v=0.
- Weight loader FSM:
  - IDLE: w_ready=0. w_load_start -> LOAD with idx=0.
  - LOAD: w_ready=1. Each w_valid cycle writes shadow[idx]; index order is idx = c*ROWS + r (column-major, matching bus order), then idx++. Accepting idx = ROWS*COLS-1 -> FULL.
  - FULL: w_ready=0, w_full=1. w_swap copies the entire shadow bank into the active bank in one edge -> IDLE.
  - w_load_start in LOAD or FULL restarts at idx=0 in LOAD; words already written stay in shadow until overwritten.
  - w_swap outside FULL is ignored.
  - w_load_start and w_swap in the same cycle while in FULL: swap wins, next state is LOAD with idx=0.
- Swap timing vs compute: a product computed on the swap edge uses the old active weights; the new weights apply from the next edge onward. Compute never stalls during load or swap.
- idx counter width = clog2(ROWS*COLS), minimum 1.

Decomposition:
- Package pe_matrix_pkg holds:
  - typedef enum logic[1:0] {SRC_BUS, SRC_DIAG_UP, SRC_DIAG_DN, SRC_HORZ}
  - typedef enum {W_IDLE, W_LOAD, W_FULL}
  - function flat_idx(c,r)
- Sub-module pe_cell contains the Q register, 4:1 mux, weight active/shadow registers and product register.
- The top level holds the generate grid with edge zero-tie, plus the loader FSM and the valid pipeline.

Test Plan (ROWS=COLS=3, DATA_W=16):
- Load and swap: load weights 1..9 then w_swap; bus_if(c,r)=10*c+r; sel all 0; in_valid 1 cycle -> two edges later out_valid=1 for exactly one cycle, P(2,1)=21*8=168, P(0,0)=0.
- Anti-diagonal shift: preload Q via bus with Q(0,2)=7, all other Q=0; then sel col1=1, in_valid -> Q(1,1)=7 and Q(1,2)=0 (edge zero). With sel col0=2, Q(0,0)=0 because the source is off-grid.
- Signed arithmetic: Q=-32768 (0x8000) and W=-1 -> P=32768 (0x0000_8000). Q=-3, W=5 -> P=0xFFFF_FFF1.
- Loader boundaries:
  - w_valid gaps during load are tolerated.
  - w_full asserts after the 9th accepted word; w_ready=0 in FULL.
  - w_swap in LOAD is ignored (active weights unchanged).
  - w_load_start mid-load resets idx so the next word lands at PE(0,0).
- Swap/compute overlap: in_valid every cycle with a constant feature of 2; swap from all-W=1 to all-W=3 on the same edge a product is computed -> that product is 2, the next one is 6.
- Reset mid-operation: RST during LOAD with 4 words in and the pipeline full -> the next cycle shows out_valid=0, bus_p=0, w_ready=0, w_full=0. A fresh complete load plus swap then behaves as in the load-and-swap test.
